// File: rtl/mapu_nxn_pkg.sv
// Shared types and helpers for the N x N matrix arithmetic unit.
package mapu_nxn_pkg;

  localparam logic [1:0] OP_ENC_ADD       = 2'd0;
  localparam logic [1:0] OP_ENC_SUB       = 2'd1;
  localparam logic [1:0] OP_ENC_MUL       = 2'd2;
  localparam logic [1:0] OP_ENC_TRANSPOSE = 2'd3;

  typedef enum logic [1:0] {
    OP_ADD       = OP_ENC_ADD,
    OP_SUB       = OP_ENC_SUB,
    OP_MUL       = OP_ENC_MUL,
    OP_TRANSPOSE = OP_ENC_TRANSPOSE
  } mapu_op_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_COMPUTE = 3'd3,
    S_DRAIN   = 3'd4
  } mapu_state_e;

  // Dot product of N products of two dw-bit values never exceeds this width.
  function automatic int acc_width(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

endpackage

// File: rtl/mapu_nxn_row_unit.sv
// One result row (N lanes) plus its overflow bit; reused for every row during COMPUTE.
module mapu_nxn_row_unit
  import mapu_nxn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 4,
  parameter int SATURATE   = 0
) (
  input  mapu_op_e                          op,
  input  logic [$clog2(N)-1:0]              row,
  input  logic [N*DATA_WIDTH-1:0]           a_row,
  input  logic [N*DATA_WIDTH-1:0]           a_col,
  input  logic [N*N*DATA_WIDTH-1:0]         b_mat,
  output logic [N*DATA_WIDTH-1:0]           c_row,
  output logic                              of
);

  localparam int DW    = DATA_WIDTH;
  localparam int ACC_W = acc_width(DW, N);

  logic [DW:0]       wide;
  logic [ACC_W-1:0]  acc;
  logic              lane_of;

  always_comb begin
    c_row   = '0;
    of      = 1'b0;
    wide    = '0;
    acc     = '0;
    lane_of = 1'b0;
    for (int c = 0; c < N; c++) begin
      wide    = '0;
      acc     = '0;
      lane_of = 1'b0;
      case (op)
        OP_ADD: begin
          wide    = {1'b0, a_row[c*DW +: DW]} + {1'b0, b_mat[(row*N + c)*DW +: DW]};
          lane_of = wide[DW];
          c_row[c*DW +: DW] = (SATURATE != 0 && lane_of) ? '1 : wide[DW-1:0];
        end
        OP_SUB: begin
          // The extra top bit of the difference is the borrow.
          wide    = {1'b0, a_row[c*DW +: DW]} - {1'b0, b_mat[(row*N + c)*DW +: DW]};
          lane_of = wide[DW];
          c_row[c*DW +: DW] = (SATURATE != 0 && lane_of) ? '0 : wide[DW-1:0];
        end
        OP_MUL: begin
          for (int k = 0; k < N; k++) begin
            acc = acc + ACC_W'(a_row[k*DW +: DW]) * ACC_W'(b_mat[(k*N + c)*DW +: DW]);
          end
          lane_of = |acc[ACC_W-1:DW];
          c_row[c*DW +: DW] = (SATURATE != 0 && lane_of) ? '1 : acc[DW-1:0];
        end
        default: begin
          c_row[c*DW +: DW] = a_col[c*DW +: DW];
        end
      endcase
      of = of | lane_of;
    end
  end

endmodule

// File: rtl/mapu_nxn.sv
// N x N matrix APU: row-streamed load of A (and B), N-cycle compute, row-streamed drain.
//   state     | meaning
//   S_IDLE    | waiting for i_en, op latched on exit
//   S_LOAD_A  | accepting N rows of A
//   S_LOAD_B  | accepting N rows of B (not used by TRANSPOSE)
//   S_COMPUTE | one result row per cycle
//   S_DRAIN   | presenting result rows downstream
module mapu_nxn
  import mapu_nxn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 4,
  parameter int SATURATE   = 0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_en,
  input  logic [1:0]               i_op,
  output logic                     o_of,
  input  logic                     i_vld,
  output logic                     o_rdy,
  input  logic [N*DATA_WIDTH-1:0]  i_row,
  output logic                     o_vld,
  input  logic                     i_rdy,
  output logic [N*DATA_WIDTH-1:0]  o_row
);

  localparam int DW = DATA_WIDTH;
  localparam int RW = N * DW;
  localparam int MW = N * RW;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_ROW = IW'(N - 1);

  mapu_state_e     state_q, state_d;
  mapu_op_e        op_q, op_d;
  logic [IW-1:0]   row_q, row_d;
  logic [MW-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [N-1:0]    of_rows_q, of_rows_d;
  logic            of_q, of_d;

  logic [RW-1:0]   a_col;
  logic [RW-1:0]   unit_row;
  logic            unit_of;

  always_comb begin
    a_col = '0;
    for (int c = 0; c < N; c++) begin
      a_col[c*DW +: DW] = a_q[(c*N + row_q)*DW +: DW];
    end
  end

  mapu_nxn_row_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (N),
    .SATURATE   (SATURATE)
  ) u_row_unit (
    .op    (op_q),
    .row   (row_q),
    .a_row (a_q[row_q*RW +: RW]),
    .a_col (a_col),
    .b_mat (b_q),
    .c_row (unit_row),
    .of    (unit_of)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    row_d     = row_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    of_rows_d = of_rows_q;
    of_d      = of_q;
    case (state_q)
      S_IDLE: begin
        if (i_en) begin
          state_d   = S_LOAD_A;
          op_d      = mapu_op_e'(i_op);
          row_d     = '0;
          of_rows_d = '0;
        end
      end
      S_LOAD_A: begin
        if (i_vld) begin
          a_d[row_q*RW +: RW] = i_row;
          if (row_q == LAST_ROW) begin
            row_d   = '0;
            state_d = (op_q == OP_TRANSPOSE) ? S_COMPUTE : S_LOAD_B;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      S_LOAD_B: begin
        if (i_vld) begin
          b_d[row_q*RW +: RW] = i_row;
          if (row_q == LAST_ROW) begin
            row_d   = '0;
            state_d = S_COMPUTE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      S_COMPUTE: begin
        res_d[row_q*RW +: RW] = unit_row;
        of_rows_d[row_q]      = unit_of;
        if (row_q == LAST_ROW) begin
          row_d   = '0;
          state_d = S_DRAIN;
          of_d    = |of_rows_d;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (i_rdy) begin
          if (row_q == LAST_ROW) begin
            row_d   = '0;
            state_d = S_IDLE;
            of_d    = 1'b0;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Dropping the enable anywhere outside IDLE discards the operation.
    if (state_q != S_IDLE && !i_en) begin
      state_d = S_IDLE;
      row_d   = '0;
      of_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_ADD;
      row_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      of_rows_q <= '0;
      of_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      row_q     <= row_d;
      a_q       <= a_d;
      b_q       <= b_d;
      res_q     <= res_d;
      of_rows_q <= of_rows_d;
      of_q      <= of_d;
    end
  end

  assign o_rdy = (state_q == S_LOAD_A) || (state_q == S_LOAD_B);
  assign o_vld = (state_q == S_DRAIN);
  assign o_of  = of_q;
  assign o_row = res_q[row_q*RW +: RW];

endmodule

// File: tb/tb_mapu_nxn.sv
// Scoreboard bench: truncating and saturating instances share stimulus; a monitor checks drained rows.
module tb_mapu_nxn;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int RW = N * DW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          i_en = 1'b0;
  logic [1:0]    i_op = 2'd0;
  logic          i_vld = 1'b0;
  logic          i_rdy = 1'b1;
  logic [RW-1:0] i_row = '0;

  logic          o_of0, o_rdy0, o_vld0, o_of1, o_rdy1, o_vld1;
  logic [RW-1:0] o_row0, o_row1;

  always #5 clk = ~clk;

  mapu_nxn #(.DATA_WIDTH(DW), .N(N), .SATURATE(0)) u_dut_trunc (
    .clk(clk), .reset_n(reset_n), .i_en(i_en), .i_op(i_op), .o_of(o_of0),
    .i_vld(i_vld), .o_rdy(o_rdy0), .i_row(i_row), .o_vld(o_vld0),
    .i_rdy(i_rdy), .o_row(o_row0)
  );

  mapu_nxn #(.DATA_WIDTH(DW), .N(N), .SATURATE(1)) u_dut_sat (
    .clk(clk), .reset_n(reset_n), .i_en(i_en), .i_op(i_op), .o_of(o_of1),
    .i_vld(i_vld), .o_rdy(o_rdy1), .i_row(i_row), .o_vld(o_vld1),
    .i_rdy(i_rdy), .o_row(o_row1)
  );

  typedef struct {
    logic [RW-1:0] r0;
    logic          f0;
    logic [RW-1:0] r1;
    logic          f1;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic push(input logic [RW-1:0] r0, input logic f0,
                      input logic [RW-1:0] r1, input logic f1);
    exp_t e;
    e.r0 = r0; e.f0 = f0; e.r1 = r1; e.f1 = f1;
    exp_q.push_back(e);
  endtask

  // Monitor: checks every accepted output row and row stability during stalls.
  logic          stall_prev = 1'b0;
  logic [RW-1:0] h0 = '0, h1 = '0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("hold_row_trunc", 64'(o_row0), 64'(h0));
          chk("hold_row_sat", 64'(o_row1), 64'(h1));
          chk("hold_vld", 64'(o_vld0), 64'd1);
        end
        if (o_vld0 && i_rdy) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_row", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            chk("row_trunc", 64'(o_row0), 64'(e.r0));
            chk("of_trunc", 64'(o_of0), 64'(e.f0));
            chk("row_sat", 64'(o_row1), 64'(e.r1));
            chk("of_sat", 64'(o_of1), 64'(e.f1));
            chk("vld_sat", 64'(o_vld1), 64'd1);
          end
        end
        stall_prev = o_vld0 && !i_rdy;
        h0 = o_row0;
        h1 = o_row1;
      end
    end
  end

  task automatic start(input logic [1:0] op);
    i_en = 1'b1;
    i_op = op;
    @(posedge clk); #1;
    i_op = ~op;
    chk("start_rdy", 64'(o_rdy0), 64'd1);
  endtask

  task automatic send_row(input logic [RW-1:0] r);
    int n = 0;
    i_vld = 1'b1;
    i_row = r;
    @(negedge clk);
    while (!o_rdy0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!o_rdy0) chk("rdy_timeout", 64'(o_rdy0), 64'd1);
    @(posedge clk); #1;
    i_vld = 1'b0;
  endtask

  task automatic send4(input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                       input logic [RW-1:0] r2, input logic [RW-1:0] r3);
    send_row(r0); send_row(r1); send_row(r2); send_row(r3);
  endtask

  task automatic wait_done(input bit toggle);
    int n = 0;
    while ((exp_q.size() != 0 || o_vld0) && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (toggle) i_rdy = ~i_rdy;
    end
    if (n >= 200) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    i_rdy = 1'b1;
    i_en  = 1'b0;
    i_vld = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  vld_seen;

    #1 reset_n = 1'b0;
    #10;
    chk("rst_rdy", 64'(o_rdy0), 64'd0);
    chk("rst_vld", 64'(o_vld0), 64'd0);
    chk("rst_of", 64'(o_of0), 64'd0);
    chk("rst_row", 64'(o_row0), 64'd0);
    chk("rst_of_sat", 64'(o_of1), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // ADD ones + twos, with latency check
    for (int r = 0; r < N; r++) push(32'h03030303, 1'b0, 32'h03030303, 1'b0);
    start(2'd0);
    send4(32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101);
    send4(32'h02020202, 32'h02020202, 32'h02020202, 32'h02020202);
    repeat (3) @(posedge clk);
    #1 chk("latency_low", 64'(o_vld0), 64'd0);
    @(posedge clk); #1;
    chk("latency_high", 64'(o_vld0), 64'd1);
    wait_done(1'b0);

    // MUL by identity
    for (int r = 0; r < N; r++) push(32'h04030201, 1'b0, 32'h04030201, 1'b0);
    start(2'd2);
    send4(32'h04030201, 32'h04030201, 32'h04030201, 32'h04030201);
    send4(32'h00000001, 32'h00000100, 32'h00010000, 32'h01000000);
    wait_done(1'b0);

    // ADD overflow in one element
    push(32'h0000002C, 1'b1, 32'h000000FF, 1'b1);
    for (int r = 1; r < N; r++) push(32'h0, 1'b1, 32'h0, 1'b1);
    start(2'd0);
    send4(32'h000000C8, 32'h0, 32'h0, 32'h0);
    send4(32'h00000064, 32'h0, 32'h0, 32'h0);
    wait_done(1'b0);

    // SUB underflow
    for (int r = 0; r < N; r++) push(32'hFEFEFEFE, 1'b1, 32'h00000000, 1'b1);
    start(2'd1);
    send4(32'h05050505, 32'h05050505, 32'h05050505, 32'h05050505);
    send4(32'h07070707, 32'h07070707, 32'h07070707, 32'h07070707);
    wait_done(1'b0);

    // MUL with B[k][c] = c: C[r][c] = 10*c
    for (int r = 0; r < N; r++) push(32'h1E140A00, 1'b0, 32'h1E140A00, 1'b0);
    start(2'd2);
    send4(32'h04030201, 32'h04030201, 32'h04030201, 32'h04030201);
    send4(32'h03020100, 32'h03020100, 32'h03020100, 32'h03020100);
    wait_done(1'b0);

    // MUL overflow: 4 * 16 * 16 = 1024
    for (int r = 0; r < N; r++) push(32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1);
    start(2'd2);
    send4(32'h10101010, 32'h10101010, 32'h10101010, 32'h10101010);
    send4(32'h10101010, 32'h10101010, 32'h10101010, 32'h10101010);
    wait_done(1'b0);

    // Abort after two A rows
    start(2'd0);
    send_row(32'h01010101);
    send_row(32'h01010101);
    i_en = 1'b0;
    @(posedge clk); #1;
    chk("abort_rdy", 64'(o_rdy0), 64'd0);
    vld_seen = 1'b0;
    repeat (16) begin
      @(posedge clk); #1;
      if (o_vld0) vld_seen = 1'b1;
    end
    chk("abort_no_vld", 64'(vld_seen), 64'd0);

    // TRANSPOSE with i_rdy toggling during drain
    push(32'h0C080400, 1'b0, 32'h0C080400, 1'b0);
    push(32'h0D090501, 1'b0, 32'h0D090501, 1'b0);
    push(32'h0E0A0602, 1'b0, 32'h0E0A0602, 1'b0);
    push(32'h0F0B0703, 1'b0, 32'h0F0B0703, 1'b0);
    start(2'd3);
    send4(32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
    chk("transpose_no_b", 64'(o_rdy0), 64'd0);
    i_vld = 1'b1;
    i_row = 32'hDEADBEEF;
    wait_done(1'b1);

    // Reset while stalled in DRAIN with overflow flagged
    i_rdy = 1'b0;
    start(2'd0);
    send4(32'h000000C8, 32'h0, 32'h0, 32'h0);
    send4(32'h00000064, 32'h0, 32'h0, 32'h0);
    n = 0;
    while (!o_vld0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_test_vld", 64'(o_vld0), 64'd1);
    chk("rst_test_of", 64'(o_of0), 64'd1);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_vld", 64'(o_vld0), 64'd0);
    chk("async_rst_of", 64'(o_of0), 64'd0);
    chk("async_rst_of_sat", 64'(o_of1), 64'd0);
    @(posedge clk); #1;
    i_en  = 1'b0;
    i_rdy = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_vld", 64'(o_vld0), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
